wave_peak_detect: RTL and testbench
===================================

// Module: wave_peak_detect
// PURPOSE
//  Upstream stage of the duty-cycle measurer: takes the 8-bit ADC sample stream and measures
//  per-window max, min and peak-to-peak. Its `amplitude` output drives the duty stage's amplitude input.
//  One result set is published per window of WIN_LEN accepted samples, with a 1-cycle meas_valid strobe.
// PARAMETERS
//  DATA_W   8     sample width
//  WIN_LEN  1024  accepted samples per measurement window (>=2)
//  FLAT_TH  8     pk_pk strictly below this -> flat=1
// PORTS
//  clk          in   1       single clock; all logic on posedge
//  rst          in   1       synchronous, active-high reset
//  sample_vld   in   1       wave_in valid this cycle
//  wave_in      in   DATA_W  unsigned ADC sample
//  amplitude    out  DATA_W  window maximum
//  trough       out  DATA_W  window minimum
//  pk_pk        out  DATA_W  amplitude - trough
//  flat         out  1       pk_pk < FLAT_TH; duty result downstream is not meaningful
//  meas_valid   out  1       1-cycle strobe: outputs updated this cycle
// BEHAVIOUR
//  - Interface: one clock `clk`; reset `rst` is synchronous and active-high.
//  - Reset: amplitude=0, trough=0, pk_pk=0, flat=1, meas_valid=0; FSM->ACCUM, sample count=0,
//    run_max=0, run_min=all-ones. Reset mid-window discards the partial window; outputs return to reset values.
//  - FSM: ACCUM -> PUBLISH -> ACCUM (2 states, no idle).
//    ACCUM: on sample_vld, run_max=max(run_max,wave_in), run_min=min(run_min,wave_in), cnt++.
//      When the WIN_LEN-th sample is accepted (cnt==WIN_LEN-1 && sample_vld), that sample is included;
//      go to PUBLISH. cnt is reset to 0.
//    PUBLISH (exactly 1 cycle): register amplitude/trough/pk_pk/flat; meas_valid=1.
//      Then reload run_max=0 and run_min=all-ones.
//      A sample_vld in this cycle IS accepted as sample 0 of the next window. It seeds both run_max and
//      run_min directly, so no sample is lost.
//  - Latency: outputs valid 1 cycle after the last window sample; meas_valid high in that same cycle.
//  - Stall: sample_vld=0 freezes cnt and running values. There is no timeout.
//  - Arithmetic: all unsigned. pk_pk = max-min never underflows (max>=min by construction).
//    cnt width = $clog2(WIN_LEN). Ties (equal samples) leave running values unchanged.
//  - Constant input v: amplitude=trough=v, pk_pk=0, flat=1.
//  - Outputs hold between strobes.
// CONFIGURATION
//  PEAK_AVG_EN defined: amplitude/trough are the mean of the last 4 window results.
//    Kept as a 4-deep history with a (DATA_W+2)-bit running sum per quantity; output = sum>>2 (truncate).
//    pk_pk and flat are computed from the averaged values.
//    History is zeroed at reset, so the first 3 published results are biased toward 0 (documented, intentional).
//  PEAK_AVG_EN undefined: raw per-window values, no history registers.
// STRUCTURE
//  - Shared package: DATA_W default, FSM state encoding (ST_ACCUM, ST_PUBLISH), FLAT_TH default.
//    The duty stage uses the same DATA_W constant.
//  - One sub-module, peak_avg4: 4-entry history plus running sum. Instantiated twice (max, min).
//    Only present under PEAK_AVG_EN.
// TESTING
//  1. WIN_LEN=16, square 20/200, vld=1 -> amplitude=200, trough=20, pk_pk=180, flat=0; strobe every 17th cycle max.
//  2. Constant 128 for 2 windows -> amplitude=trough=128, pk_pk=0, flat=1 on both strobes.
//  3. vld toggling 1/0 -> strobe exactly after 16 accepted samples (32 cycles); extremes on vld=0 cycles ignored.
//  4. Sample of 255 presented in a PUBLISH cycle -> appears as next window's amplitude=255, not the current one.
//  5. rst after 8 samples, then 16 samples of 50..65 -> first strobe gives trough=50, amplitude=65 (pre-reset data gone).
//  6. PEAK_AVG_EN, windows with max 100,200,100,200 -> 4th strobe amplitude=150; 1st strobe amplitude=25.

Source files
------------

// File: rtl/wave_peak_detect_pkg.sv
// Shared constants and FSM encoding for the waveform front end.
// DATA_W is also used by the downstream duty-cycle stage.
package wave_peak_detect_pkg;

    // ADC sample width shared by this stage and the duty stage.
    localparam int DATA_W_DEF  = 8;

    // Peak-to-peak below this means the waveform is treated as flat.
    localparam int FLAT_TH_DEF = 8;

    // Default number of accepted samples per measurement window.
    localparam int WIN_LEN_DEF = 1024;

    // Depth of the optional result-averaging history.
    localparam int AVG_DEPTH   = 4;

    typedef enum logic {
        ST_ACCUM   = 1'b0,
        ST_PUBLISH = 1'b1
    } state_t;

endpackage

// File: rtl/wave_peak_detect_peak_avg4.sv
// Four-deep history of window results with a running sum.
// Ports: clk, rst (sync, active-high), push (new result), din (result),
// avg_next (mean of the history including din, valid while push=1).
// Only built when PEAK_AVG_EN is defined.
`ifdef PEAK_AVG_EN
module peak_avg4
    import wave_peak_detect_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] avg_next
);

    localparam int SUM_W = DATA_W + 2;

    logic [DATA_W-1:0] hist [AVG_DEPTH];
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  sum_next;

    // The oldest entry leaves as the new one enters, so the sum
    // always covers exactly the four most recent results.
    assign sum_next = sum + SUM_W'(din) - SUM_W'(hist[AVG_DEPTH-1]);

    // Divide by four with truncation.
    assign avg_next = sum_next[SUM_W-1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < AVG_DEPTH; i++) begin
                hist[i] <= '0;
            end
            sum <= '0;
        end else if (push) begin
            hist[0] <= din;
            for (int i = 1; i < AVG_DEPTH; i++) begin
                hist[i] <= hist[i-1];
            end
            sum <= sum_next;
        end
    end

endmodule
`endif

// File: rtl/wave_peak_detect.sv
// Per-window max / min / peak-to-peak of the ADC sample stream.
// Ports: clk, rst (sync, active-high), sample_vld, wave_in;
// outputs amplitude (max), trough (min), pk_pk, flat, meas_valid (strobe).
// Define PEAK_AVG_EN to publish the mean of the last 4 window results.
module wave_peak_detect
    import wave_peak_detect_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int WIN_LEN = WIN_LEN_DEF,
    parameter int FLAT_TH = FLAT_TH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_vld,
    input  logic [DATA_W-1:0] wave_in,
    output logic [DATA_W-1:0] amplitude,
    output logic [DATA_W-1:0] trough,
    output logic [DATA_W-1:0] pk_pk,
    output logic              flat,
    output logic              meas_valid
);

    localparam int CNT_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_LEN - 1);

    localparam logic [DATA_W:0] FLAT_THV = (DATA_W + 1)'(FLAT_TH);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] run_max;
    logic [DATA_W-1:0] run_min;

    logic [DATA_W-1:0] nxt_max;
    logic [DATA_W-1:0] nxt_min;
    logic              win_done;

    logic [DATA_W-1:0] res_max;
    logic [DATA_W-1:0] res_min;
    logic [DATA_W-1:0] res_pk;
    logic              res_flat;

    // Running extremes including the sample on the bus this cycle.
    // Strict compares: equal samples leave the running value alone.
    assign nxt_max = (wave_in > run_max) ? wave_in : run_max;
    assign nxt_min = (wave_in < run_min) ? wave_in : run_min;

    // The last sample of the window is folded straight into the
    // published result, so the strobe lands one cycle after it.
    assign win_done = (state == ST_ACCUM) && sample_vld
                   && (cnt == CNT_LAST);

`ifdef PEAK_AVG_EN
    peak_avg4 #(
        .DATA_W   (DATA_W)
    ) u_avg_max (
        .clk      (clk),
        .rst      (rst),
        .push     (win_done),
        .din      (nxt_max),
        .avg_next (res_max)
    );

    peak_avg4 #(
        .DATA_W   (DATA_W)
    ) u_avg_min (
        .clk      (clk),
        .rst      (rst),
        .push     (win_done),
        .din      (nxt_min),
        .avg_next (res_min)
    );
`else
    assign res_max = nxt_max;
    assign res_min = nxt_min;
`endif

    // max >= min per window, and the truncated means keep that order,
    // so the subtraction never wraps.
    assign res_pk   = res_max - res_min;
    assign res_flat = ({1'b0, res_pk} < FLAT_THV);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_ACCUM;
            cnt        <= '0;
            run_max    <= '0;
            run_min    <= '1;
            amplitude  <= '0;
            trough     <= '0;
            pk_pk      <= '0;
            flat       <= 1'b1;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            unique case (state)
                ST_ACCUM: begin
                    if (win_done) begin
                        cnt        <= '0;
                        state      <= ST_PUBLISH;
                        amplitude  <= res_max;
                        trough     <= res_min;
                        pk_pk      <= res_pk;
                        flat       <= res_flat;
                        meas_valid <= 1'b1;
                    end else if (sample_vld) begin
                        cnt     <= cnt + 1'b1;
                        run_max <= nxt_max;
                        run_min <= nxt_min;
                    end
                end
                ST_PUBLISH: begin
                    state <= ST_ACCUM;
                    // A sample here opens the next window; it seeds
                    // both extremes instead of comparing to stale data.
                    if (sample_vld) begin
                        run_max <= wave_in;
                        run_min <= wave_in;
                        cnt     <= CNT_W'(1);
                    end else begin
                        run_max <= '0;
                        run_min <= '1;
                        cnt     <= '0;
                    end
                end
                default: begin
                    state <= ST_ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wave_peak_detect.sv
// Directed plus random stimulus for wave_peak_detect (WIN_LEN=16),
// checked every cycle against a window-list reference model.
module tb_wave_peak_detect;

    localparam int DW = 8;
    localparam int WL = 16;
    localparam int FT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_vld;
    logic [DW-1:0] wave_in;
    logic [DW-1:0] amplitude;
    logic [DW-1:0] trough;
    logic [DW-1:0] pk_pk;
    logic          flat;
    logic          meas_valid;

    always #5 clk = ~clk;

    wave_peak_detect #(
        .DATA_W     (DW),
        .WIN_LEN    (WL),
        .FLAT_TH    (FT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_vld (sample_vld),
        .wave_in    (wave_in),
        .amplitude  (amplitude),
        .trough     (trough),
        .pk_pk      (pk_pk),
        .flat       (flat),
        .meas_valid (meas_valid)
    );

    int compared   = 0;
    int mismatched = 0;

    int win  [$];
    int hmax [$];
    int hmin [$];
    int e_amp, e_tr, e_pk, e_flat, e_mv;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        win.delete();
        hmax   = '{0, 0, 0, 0};
        hmin   = '{0, 0, 0, 0};
        e_amp  = 0;
        e_tr   = 0;
        e_pk   = 0;
        e_flat = 1;
        e_mv   = 0;
    endtask

    // A window closes on its WL-th accepted sample; the results are
    // visible right after that clock edge together with the strobe.
    task automatic model_edge(input bit r, input bit v, input int d);
        int mx, mn;
        if (r) begin
            model_reset();
            return;
        end
        e_mv = 0;
        if (v) begin
            win.push_back(d);
            if (win.size() == WL) begin
                mx = 0;
                mn = 255;
                foreach (win[i]) begin
                    if (win[i] > mx) mx = win[i];
                    if (win[i] < mn) mn = win[i];
                end
`ifdef PEAK_AVG_EN
                hmax.push_front(mx);
                void'(hmax.pop_back());
                hmin.push_front(mn);
                void'(hmin.pop_back());
                mx = (hmax[0] + hmax[1] + hmax[2] + hmax[3]) / 4;
                mn = (hmin[0] + hmin[1] + hmin[2] + hmin[3]) / 4;
`endif
                e_amp  = mx;
                e_tr   = mn;
                e_pk   = mx - mn;
                e_flat = (e_pk < FT) ? 1 : 0;
                e_mv   = 1;
                win.delete();
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input int d);
        rst        = r;
        sample_vld = v;
        wave_in    = d[DW-1:0];
        @(posedge clk);
        #1;
        model_edge(r, v, d);
        check("meas_valid", {31'd0, meas_valid}, e_mv);
        check("amplitude", {24'd0, amplitude}, e_amp);
        check("trough", {24'd0, trough}, e_tr);
        check("pk_pk", {24'd0, pk_pk}, e_pk);
        check("flat", {31'd0, flat}, e_flat);
    endtask

    int strobes;
    int x;
    int t6 [4];

    initial begin
        model_reset();
        rst        = 1'b1;
        sample_vld = 1'b0;
        wave_in    = '0;

        // Reset state
        step(1, 0, 0);
        step(1, 1, 77);
        check("rst_flat", {31'd0, flat}, 1);

        // Square wave 20/200, continuous valid, two windows
        for (int i = 0; i < 2 * WL; i++) step(0, 1, (i % 2) ? 200 : 20);
        step(0, 0, 0);
`ifndef PEAK_AVG_EN
        check("t1_amp", {24'd0, amplitude}, 200);
        check("t1_trough", {24'd0, trough}, 20);
        check("t1_pkpk", {24'd0, pk_pk}, 180);
        check("t1_flat", {31'd0, flat}, 0);
`endif

        // Constant 128 for two windows
        for (int i = 0; i < 2 * WL; i++) step(0, 1, 128);
        step(0, 0, 0);
        check("t2_pkpk", {24'd0, pk_pk}, 0);
        check("t2_flat", {31'd0, flat}, 1);

        // Valid toggling; extremes on idle cycles must be ignored
        strobes = 0;
        for (int i = 0; i < 2 * WL; i++) begin
            if (i % 2 == 0) step(0, 1, 60 + int'($urandom_range(0, 40)));
            else            step(0, 0, (i % 4 == 1) ? 255 : 0);
            strobes += meas_valid;
        end
        check("t3_strobes", strobes, 1);

        // 255 offered in the publish cycle belongs to the next window
        for (int i = 0; i < WL; i++) step(0, 1, 10);
        check("t4_strobe", {31'd0, meas_valid}, 1);
        step(0, 1, 255);
        for (int i = 1; i < WL; i++) step(0, 1, 10);
        step(0, 0, 0);
`ifndef PEAK_AVG_EN
        check("t4_amp", {24'd0, amplitude}, 255);
`endif

        // Reset mid-window discards the partial window
        step(1, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, (i % 2) ? 250 : 5);
        step(1, 0, 0);
        for (int i = 0; i < WL; i++) step(0, 1, 50 + i);
        step(0, 0, 0);
`ifdef PEAK_AVG_EN
        check("t5_trough", {24'd0, trough}, 12);
        check("t5_amp", {24'd0, amplitude}, 16);
`else
        check("t5_trough", {24'd0, trough}, 50);
        check("t5_amp", {24'd0, amplitude}, 65);
`endif

        // Window maxima 100,200,100,200 from a fresh reset
        step(1, 0, 0);
        t6 = '{100, 200, 100, 200};
        for (int w = 0; w < 4; w++) begin
            for (int i = 0; i < WL; i++) step(0, 1, t6[w]);
            step(0, 0, 0);
`ifdef PEAK_AVG_EN
            if (w == 0) check("t6_first", {24'd0, amplitude}, 25);
            if (w == 3) check("t6_fourth", {24'd0, amplitude}, 150);
`else
            if (w == 0) check("t6_first", {24'd0, amplitude}, 100);
            if (w == 3) check("t6_fourth", {24'd0, amplitude}, 200);
`endif
        end

        // Random valid pattern and data, occasional reset
        for (int i = 0; i < 1500; i++) begin
            x = int'($urandom_range(0, 255));
            if ($urandom_range(0, 299) == 0) step(1, 0, x);
            else step(0, $urandom_range(0, 9) < 7, x);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
